// File: rtl/vga_sprite_mixer_if.sv
// Pixel-stage bundle between the VGA timing generator and the sprite mixer.
// Latency: none. This file only declares the signals.
// Backpressure: none; the pixel stream is paced only by the pixel_clk enable.
//
// Port summary:
//   Timing side (master drives): pixel_clk, hsync, vsync, display_on, hpos, vpos.
//   Mixer side (slave drives):   vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_tick.
interface vga_sprite_mixer_if #(
   parameter int HPOS_WIDTH = 10,
   parameter int VPOS_WIDTH = 10
);
   logic                  pixel_clk;
   logic                  hsync;
   logic                  vsync;
   logic                  display_on;
   logic [HPOS_WIDTH-1:0] hpos;
   logic [VPOS_WIDTH-1:0] vpos;
   logic                  vga_hsync;
   logic                  vga_vsync;
   logic [1:0]            vga_r;
   logic [1:0]            vga_g;
   logic [1:0]            vga_b;
   logic                  frame_tick;

   modport master (
      output pixel_clk, hsync, vsync, display_on, hpos, vpos,
      input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_tick
   );

   modport slave (
      input  pixel_clk, hsync, vsync, display_on, hpos, vpos,
      output vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_tick
   );
endinterface

// File: rtl/vga_sprite_mixer.sv
// Two-layer pixel mixer: checkerboard background with a bouncing square sprite on top.
// Latency: N_MIXER_PIPE_STAGES pixel enables from timing inputs to RGB/sync outputs.
// Backpressure: none; the pipeline advances only on pixel_clk and holds between enables.
//
// Ports: clk, rst (synchronous, active-high), vif (slave side of vga_sprite_mixer_if).
// Optional feature: define VGA_MIXER_BORDER_EN to paint a white 1-pixel frame
// around the visible area, overriding the sprite and checker layers.
module vga_sprite_mixer #(
   parameter int         N_MIXER_PIPE_STAGES = 2,
   parameter int         HPOS_WIDTH          = 10,
   parameter int         VPOS_WIDTH          = 10,
   parameter int         H_DISPLAY           = 640,
   parameter int         V_DISPLAY           = 480,
   parameter int         SPRITE_SIZE         = 32,
   parameter int         SPRITE_SPEED        = 2,
   parameter int         X_INIT              = 100,
   parameter int         Y_INIT              = 60,
   parameter logic [5:0] SPRITE_RGB          = 6'b110000,
   parameter logic [5:0] CHECKER_RGB         = 6'b000001
) (
   input logic              clk,
   input logic              rst,
   vga_sprite_mixer_if.slave vif
);
   localparam int N    = N_MIXER_PIPE_STAGES;
   localparam int XW   = HPOS_WIDTH + 1;
   localparam int YW   = VPOS_WIDTH + 1;
   localparam int XMAX = H_DISPLAY - SPRITE_SIZE;
   localparam int YMAX = V_DISPLAY - SPRITE_SIZE;

   typedef enum logic {ST_IDLE, ST_UPDATE} state_t;

   state_t                  state;
   logic                    vsync_prev;
   logic                    frame_tick;
   logic [HPOS_WIDTH-1:0]   sprite_x;
   logic [VPOS_WIDTH-1:0]   sprite_y;
   logic                    dir_x_pos;
   logic                    dir_y_pos;

   logic [N-1:0][5:0]       col_pipe;
   logic [N-1:0]            hs_pipe;
   logic [N-1:0]            vs_pipe;

   logic [5:0]              pix_col;
   logic [HPOS_WIDTH-1:0]   next_x;
   logic [VPOS_WIDTH-1:0]   next_y;
   logic                    next_dir_x;
   logic                    next_dir_y;
   logic [XW-1:0]           x_fwd;
   logic [YW-1:0]           y_fwd;

   // Stage-1 colour select. Compares are one bit wider than the coordinates so
   // sprite_x + SPRITE_SIZE cannot wrap near the right/bottom edge.
   always_comb begin
      logic [XW-1:0] h_ext, sx_ext;
      logic [YW-1:0] v_ext, sy_ext;
      h_ext   = {1'b0, vif.hpos};
      v_ext   = {1'b0, vif.vpos};
      sx_ext  = {1'b0, sprite_x};
      sy_ext  = {1'b0, sprite_y};
      pix_col = 6'b000000;
      if (vif.display_on) begin
         if ((h_ext >= sx_ext) && (h_ext < sx_ext + XW'(SPRITE_SIZE)) &&
             (v_ext >= sy_ext) && (v_ext < sy_ext + YW'(SPRITE_SIZE)))
            pix_col = SPRITE_RGB;
         else if (vif.hpos[5] ^ vif.vpos[5])
            pix_col = CHECKER_RGB;
`ifdef VGA_MIXER_BORDER_EN
         if ((vif.hpos == HPOS_WIDTH'(0)) || (vif.hpos == HPOS_WIDTH'(H_DISPLAY - 1)) ||
             (vif.vpos == VPOS_WIDTH'(0)) || (vif.vpos == VPOS_WIDTH'(V_DISPLAY - 1)))
            pix_col = 6'b111111;
`endif
      end
   end

   // Next sprite position: bounce with clamping at both walls, never wrapping.
   always_comb begin
      x_fwd      = {1'b0, sprite_x} + XW'(SPRITE_SPEED);
      y_fwd      = {1'b0, sprite_y} + YW'(SPRITE_SPEED);
      next_x     = sprite_x;
      next_y     = sprite_y;
      next_dir_x = dir_x_pos;
      next_dir_y = dir_y_pos;
      if (dir_x_pos) begin
         if (x_fwd >= XW'(XMAX)) begin
            next_x     = HPOS_WIDTH'(XMAX);
            next_dir_x = 1'b0;
         end else begin
            next_x = x_fwd[HPOS_WIDTH-1:0];
         end
      end else if (sprite_x <= HPOS_WIDTH'(SPRITE_SPEED)) begin
         next_x     = '0;
         next_dir_x = 1'b1;
      end else begin
         next_x = sprite_x - HPOS_WIDTH'(SPRITE_SPEED);
      end
      if (dir_y_pos) begin
         if (y_fwd >= YW'(YMAX)) begin
            next_y     = VPOS_WIDTH'(YMAX);
            next_dir_y = 1'b0;
         end else begin
            next_y = y_fwd[VPOS_WIDTH-1:0];
         end
      end else if (sprite_y <= VPOS_WIDTH'(SPRITE_SPEED)) begin
         next_y     = '0;
         next_dir_y = 1'b1;
      end else begin
         next_y = sprite_y - VPOS_WIDTH'(SPRITE_SPEED);
      end
   end

   // Colour and sync pipeline; stage 0 is the registered layer mix.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_pipe <= '0;
         hs_pipe  <= '1;
         vs_pipe  <= '1;
      end else if (vif.pixel_clk) begin
         col_pipe[0] <= pix_col;
         hs_pipe[0]  <= vif.hsync;
         vs_pipe[0]  <= vif.vsync;
         for (int i = 1; i < N; i++) begin
            col_pipe[i] <= col_pipe[i-1];
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
         end
      end
   end

   // Frame update FSM. The falling vsync edge lands in blanking, so moving the
   // sprite one clk later never changes it mid visible frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         vsync_prev <= 1'b1;
         frame_tick <= 1'b0;
         sprite_x   <= HPOS_WIDTH'(X_INIT);
         sprite_y   <= VPOS_WIDTH'(Y_INIT);
         dir_x_pos  <= 1'b1;
         dir_y_pos  <= 1'b1;
      end else begin
         frame_tick <= 1'b0;
         if (vif.pixel_clk)
            vsync_prev <= vif.vsync;
         case (state)
            ST_IDLE: begin
               if (vif.pixel_clk && vsync_prev && !vif.vsync)
                  state <= ST_UPDATE;
            end
            ST_UPDATE: begin
               sprite_x   <= next_x;
               sprite_y   <= next_y;
               dir_x_pos  <= next_dir_x;
               dir_y_pos  <= next_dir_y;
               frame_tick <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign vif.vga_hsync  = hs_pipe[N-1];
   assign vif.vga_vsync  = vs_pipe[N-1];
   assign vif.vga_r      = col_pipe[N-1][5:4];
   assign vif.vga_g      = col_pipe[N-1][3:2];
   assign vif.vga_b      = col_pipe[N-1][1:0];
   assign vif.frame_tick = frame_tick;
endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Bench for vga_sprite_mixer: random pixels and frames against a reference model.
// Latency: expects outputs N_PIPE pixel enables after the inputs.
// Backpressure: none; pixel_clk is pulsed every second clk.
module tb_vga_sprite_mixer;
   localparam int N_PIPE = 2;
   localparam int HD     = 640;
   localparam int VD     = 480;
   localparam int SZ     = 32;
   localparam int SPD    = 2;

   logic clk;
   logic rst;

   vga_sprite_mixer_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10)) vif ();

   vga_sprite_mixer #(.N_MIXER_PIPE_STAGES(N_PIPE)) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model state, in plain integers.
   int mx, my, mdx, mdy;
   bit m_vs_prev;
   logic [7:0] expq[$];

   function automatic logic [5:0] ref_rgb(input bit de, input int h, input int v);
      if (!de) return 6'b000000;
`ifdef VGA_MIXER_BORDER_EN
      if (h == 0 || h == HD - 1 || v == 0 || v == VD - 1) return 6'b111111;
`endif
      if (h >= mx && h < mx + SZ && v >= my && v < my + SZ) return 6'b110000;
      if (((h / 32) % 2) != ((v / 32) % 2)) return 6'b000001;
      return 6'b000000;
   endfunction

   // Bounce one axis within [0, lim].
   task automatic bounce(inout int pos, inout int dir, input int lim);
      if (dir > 0) begin
         if (pos + SPD >= lim) begin pos = lim; dir = -1; end
         else pos = pos + SPD;
      end else begin
         if (pos <= SPD) begin pos = 0; dir = 1; end
         else pos = pos - SPD;
      end
   endtask

   task automatic model_reset();
      mx = 100; my = 60; mdx = 1; mdy = 1;
      m_vs_prev = 1'b1;
      expq.delete();
      for (int i = 0; i < N_PIPE - 1; i++) expq.push_back(8'b1100_0000);
   endtask

   function automatic logic [7:0] dut_out();
      return {vif.vga_hsync, vif.vga_vsync, vif.vga_r, vif.vga_g, vif.vga_b};
   endfunction

   // One pixel enable followed by one idle clk; called #1 after a posedge.
   task automatic pix(input bit hs, input bit vs, input bit de, input int h, input int v);
      bit upd;
      vif.hsync      = hs;
      vif.vsync      = vs;
      vif.display_on = de;
      vif.hpos       = h[9:0];
      vif.vpos       = v[9:0];
      vif.pixel_clk  = 1'b1;
      upd = m_vs_prev && !vs;
      m_vs_prev = vs;
      expq.push_back({hs, vs, ref_rgb(de, h, v)});
      @(posedge clk); #1;
      vif.pixel_clk = 1'b0;
      check("pix_out", 32'(dut_out()), 32'(expq.pop_front()));
      check("tick_idle", 32'(vif.frame_tick), 32'(0));
      @(posedge clk); #1;
      check("frame_tick", 32'(vif.frame_tick), 32'(upd));
      if (upd) begin
         bounce(mx, mdx, HD - SZ);
         bounce(my, mdy, VD - SZ);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag, 32'({dut_out(), vif.frame_tick}), 32'(9'b1100_0000_0));
   endtask

   // Probe pixels around the model sprite plus a fully random one.
   task automatic probe_sprite();
      for (int k = 0; k < 4; k++) begin
         int h, v;
         h = mx + int'($urandom_range(0, SZ + 1)) - 1;
         v = my + int'($urandom_range(0, SZ + 1)) - 1;
         if (h < 0) h = 0;
         if (v < 0) v = 0;
         pix(1'($urandom), 1'b1, 1'b1, h, v);
      end
      pix(1'($urandom), 1'b1, 1'($urandom), int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
   endtask

   initial begin
      rst            = 1'b1;
      vif.pixel_clk  = 1'b1;
      vif.hsync      = 1'b0;
      vif.vsync      = 1'b0;
      vif.display_on = 1'b1;
      vif.hpos       = 10'd110;
      vif.vpos       = 10'd70;
      model_reset();
      // Reset dominates an active pixel enable.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst = 1'b0;
      vif.pixel_clk = 1'b0;
      vif.vsync = 1'b1;
      vif.hsync = 1'b1;

      // Directed pixels: sprite hit, blanking, lit checker, sync toggles.
      pix(1, 1, 1, 110, 70);
      pix(0, 1, 1, 110, 70);
      pix(1, 1, 0, 110, 70);
      pix(1, 1, 1, 200, 32);
      pix(0, 1, 1, 99, 70);
      pix(1, 1, 1, 131, 91);
      pix(1, 1, 1, 132, 91);
      // Screen-edge pixels (white under the border build).
      pix(1, 1, 1, 0, 240);
      pix(1, 1, 1, 639, 100);
      pix(1, 1, 1, 300, 0);
      pix(1, 1, 1, 300, 479);

      // Frames: enough updates to bounce off the bottom and right walls.
      for (int f = 0; f < 300; f++) begin
         pix(1'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 799)), int'($urandom_range(480, 520)));
         pix(1'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 799)), int'($urandom_range(480, 520)));
         pix(1'($urandom), 1'b1, 1'b0, int'($urandom_range(0, 799)), int'($urandom_range(480, 520)));
         probe_sprite();
      end

      // Reset while the UPDATE state is pending and the pipeline is full.
      pix(0, 1, 1, 200, 32);
      vif.vsync     = 1'b0;
      vif.pixel_clk = 1'b1;
      @(posedge clk); #1;
      vif.pixel_clk = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("reset_mid_update");
      rst = 1'b0;
      vif.vsync = 1'b1;
      model_reset();
      pix(1, 1, 1, 100, 60);
      pix(1, 1, 1, 99, 60);
      pix(1, 1, 1, 100, 59);
      pix(1, 0, 0, 0, 490);
      pix(1, 1, 1, 100, 60);
      pix(1, 1, 1, 101, 61);
      pix(1, 1, 1, 133, 93);
      pix(1, 1, 1, 134, 94);
      probe_sprite();
      pix(1, 1, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
